// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern source and its 1010 marker.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } state_t;

  localparam logic [3:0]  SEQ_1010       = 4'b1010;
  localparam logic [19:0] SEQ_TB_DEFAULT = 20'b00101010001001010110;

endpackage

// File: rtl/seq_1010_marker.sv
// Golden overlapping 1010 Mealy detector: 3-bit history of valid bits plus a compare.
module seq_1010_marker
  import seq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic x,
  output logic mark
);

  logic [2:0] hist;

  // hist[2] is the oldest bit; only valid cycles advance the history.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      hist <= '0;
    end else if (en) begin
      hist <= {hist[1:0], x};
    end
  end

  assign mark = en && ({hist, x} == SEQ_1010);

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern source (MSB first) with one-shot/repeat, pause and stop,
// plus the expected response of an overlapping 1010 Mealy detector.
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int LEN = 20,
  parameter int CW  = $clog2(LEN + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic [LEN-1:0] pat,
  input  logic [CW-1:0]  len,
  input  logic           repeat_en,
  input  logic           start,
  input  logic           pause,
  input  logic           stop,
  output logic           x,
  output logic           x_valid,
  output logic           busy,
  output logic           done,
  output logic           mark,
  output logic [CW-1:0]  bit_idx,
  output logic [7:0]     match_cnt
);

  localparam logic [CW-1:0] LEN_MAX = CW'(LEN);
  localparam logic [CW-1:0] IDX_ONE = CW'(1);

  state_t         state_q, state_d;
  logic [LEN-1:0] pat_q, emit_pat;
  logic [CW-1:0]  len_q, len_clamp, eff_len, next_idx, emit_idx;
  logic           rep_q, rep_next, emit, start_run, done_d, emit_bit;

  // A load in the same cycle as start takes effect first, so start sees the new pattern.
  assign len_clamp = (len > LEN_MAX) ? LEN_MAX : len;
  assign eff_len   = load ? len_clamp : len_q;
  assign emit_pat  = (state_q == IDLE && load) ? pat : pat_q;
  assign rep_next  = (state_q == IDLE) ? repeat_en : rep_q;
  assign next_idx  = (bit_idx == '0) ? len_q - IDX_ONE : bit_idx - IDX_ONE;
  assign emit_bit  = emit_pat[emit_idx];
  assign done_d    = emit && (emit_idx == '0) && !rep_next;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    emit      = 1'b0;
    emit_idx  = bit_idx;
    start_run = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && eff_len != '0) begin
          state_d   = RUN;
          emit      = 1'b1;
          emit_idx  = eff_len - IDX_ONE;
          start_run = 1'b1;
        end
      end
      // stop beats end-of-pattern, which beats pause (done was already shown).
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (bit_idx == '0 && !rep_q) begin
          state_d = IDLE;
        end else if (pause) begin
          state_d = PAUSE;
        end else begin
          emit     = 1'b1;
          emit_idx = next_idx;
        end
      end
      PAUSE: begin
        if (stop) begin
          state_d = IDLE;
        end else if (!pause) begin
          state_d  = RUN;
          emit     = 1'b1;
          emit_idx = next_idx;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      rep_q     <= 1'b0;
      x         <= 1'b0;
      x_valid   <= 1'b0;
      bit_idx   <= '0;
      done      <= 1'b0;
      match_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && load) begin
        pat_q <= pat;
        len_q <= len_clamp;
      end
      if (start_run) begin
        rep_q <= repeat_en;
      end
      // PAUSE keeps the last bit and index on the bus but marks it invalid.
      if (emit) begin
        x       <= emit_bit;
        x_valid <= 1'b1;
        bit_idx <= emit_idx;
      end else if (state_d == PAUSE) begin
        x_valid <= 1'b0;
      end else begin
        x       <= 1'b0;
        x_valid <= 1'b0;
        bit_idx <= '0;
      end
      done <= done_d;
      if (start_run) begin
        match_cnt <= '0;
      end else if (mark && match_cnt != 8'hFF) begin
        match_cnt <= match_cnt + 8'd1;
      end
    end
  end

  seq_1010_marker u_marker (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_run),
    .en    (x_valid),
    .x     (x),
    .mark  (mark)
  );

endmodule

// File: doc/seq_pattern_gen.md
# seq_pattern_gen

Serial bit-stream source that drives a single-bit `x` line with a loaded pattern, one bit per clock, MSB first. It is the transmitting end of the sequence-detector interface: it feeds detectors such as the 1010 Mealy overlap detector. It also produces `mark`, the cycle-exact response an overlapping 1010 Mealy detector must give, so benches can compare against it directly. It supports one-shot and repeat modes, pause, and abort.

## Interface
- `LEN`, 20, maximum pattern length in bits
- `CW`, `$clog2(LEN+1)`, width of length/index fields
- `clk`  in  1  clock, all logic on rising edge
- `rst_n`  in  1  synchronous active-low reset
- `load`  in  1  capture `pat`/`len` into shadow registers (IDLE only)
- `pat`  in  LEN  pattern; bit `len-1` is sent first, bit 0 last
- `len`  in  CW  pattern length; values > LEN clamp to LEN
- `repeat_en`  in  1  sampled with `start`; 1 = wrap continuously
- `start`  in  1  begin transmission
- `pause`  in  1  level; freeze stream while high
- `stop`  in  1  abort transmission
- `x`  out  1  serial data to detector
- `x_valid`  out  1  `x` carries a pattern bit this cycle
- `busy`  out  1  state is not IDLE
- `done`  out  1  one-cycle pulse on the last bit of a one-shot run
- `mark`  out  1  expected Mealy 1010-overlap detector output for current `x`
- `bit_idx`  out  CW  index of the pattern bit currently on `x`
- `match_cnt`  out  8  count of `mark` pulses since start, saturating at 255

## Operation
- States: IDLE, RUN, PAUSE.
- Reset (`rst_n`=0 at an edge): IDLE. All outputs 0. Shadow `pat`/`len`/`repeat` cleared. History cleared.
- IDLE:
  - `load` captures `pat` and `min(len,LEN)`.
  - `start` with shadow len ≠ 0 goes to RUN. It latches `repeat_en`, clears history and `match_cnt`, and sets `bit_idx`=len-1.
  - `start` with len=0 is ignored: no `busy`, no `done`.
  - `load` and `start` in the same cycle: load applies first, and start uses the new pattern.
- RUN:
  - Each cycle outputs `x`=pat[bit_idx] with `x_valid`=1, then decrements `bit_idx`.
  - At `bit_idx`=0, one-shot mode asserts `done` and goes to IDLE. Repeat mode wraps to len-1 with no gap bit.
- `pause` in RUN goes to PAUSE.
  - PAUSE holds `x` and `bit_idx`, drives `x_valid`=0 and `mark`=0, and leaves history untouched.
  - Deasserting `pause` returns to RUN and emits the next bit.
- `stop` in RUN or PAUSE goes to IDLE with no `done`. `stop` has priority over `pause` and over end-of-pattern.
- `load` outside IDLE is ignored.
- In IDLE, `x` and `x_valid`, `mark` and `done` are all 0. `match_cnt` holds.
- `mark` = x_valid & ({h2,h1,h0,x} == 4'b1010).
  - h is a 3-bit history of prior valid bits and shifts only on valid cycles.
  - Overlap is allowed, including across a repeat wrap.
- `match_cnt` increments on each `mark` and saturates.

## Timing
- Cycle 0 is the cycle after the edge that samples `start`. Bit k (k=0..len-1) is on `x` in cycle k. So `x`, `x_valid` and `bit_idx` are registered with 1-cycle latency from `start`.
- `mark` is combinational from registered `x` and history, valid in the same cycle as its bit. `match_cnt` updates one cycle after `mark`.
- `done` is asserted in cycle len-1, together with the last bit. `busy` falls in cycle len.
- A new `start` is accepted in the first IDLE cycle, giving a 1-cycle gap between back-to-back runs.
- `pause` and `stop` sampled at edge n take effect in cycle n+1.
- Reset mid-run: the next cycle is IDLE with all outputs 0. No `done` pulse.

## Structure
- Package `seq_pkg`:
  - `state_t` enum {IDLE, RUN, PAUSE}
  - `SEQ_1010` = 4'b1010
  - `SEQ_TB_DEFAULT` = 20'b00101010001001010110
- Sub-module `seq_1010_marker`: 3-bit history shift register plus compare. Inputs are `clk`, `rst_n`, `clr`, `en`, `x`. Output is `mark`. It is reusable as a golden model in detector benches.

## Test plan
- Reset, load `SEQ_TB_DEFAULT`, len=20, one-shot start → bits 0..19 emitted in order. `mark` high only at k=5, 7, 16. `done` at k=19. `match_cnt`=3.
- Load 4'b1010, len=4, `repeat_en`=1, start, run 12 cycles, then `stop` → `mark` at k=3, 5, 7, 9, 11. No `done`. IDLE one cycle after `stop`.
- Default pattern with `pause` high for 3 cycles starting at k=6 → `x_valid`=0 and `x` held during the pause. The bit stream is unchanged. Marks still at bits 5, 7, 16.
- `start` with len=0, and `load` during RUN → len=0 start is ignored (`busy` stays 0). Load during RUN leaves the current pattern unchanged. `load`+`start` in the same cycle sends the new pattern.
- `rst_n` low at k=10 of a one-shot run → next cycle all outputs 0 and state IDLE. A fresh start replays from k=0.
